// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- main control FSM for a multicycle MIPS-style datapath.
//
// Sequences each instruction through FETCH / DECODE and an opcode-specific
// execute path (lw, sw, R-format, beq, j), drives the datapath mux selects and
// write enables, counts retired instructions and traps on undefined opcodes.
//
// Ports
//   clk        system clock (rising edge)
//   reset      asynchronous, active-high reset
//   opcode     instruction[31:26], stable from DECODE onward
//   mem_ready  memory completes the current access this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite,
//   ALUSrcA, RegWrite, RegDest      1-bit datapath controls
//   ALUSrcB    ALU B-operand select
//   ALUOp      ALU operation class: 00 add, 01 sub, 10 funct
//   PCSource   PC mux select: 00 ALU, 01 ALUOut, 10 jump
//   state      current state encoding
//   illegal    sticky undefined-opcode flag
//   retired    completed-instruction count (wraps at 16 bits)
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        IRWrite,
  output logic        ALUSrcA,
  output logic        RegWrite,
  output logic        RegDest,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [15:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    REXEC  = 4'd7,
    RWB    = 4'd8,
    BEQ    = 4'd9,
    JUMP   = 4'd10,
    TRAP   = 4'd11
  } state_t;

  state_t cur;

  // State, sticky trap flag and retire counter. An instruction retires on the
  // edge that leaves its last state; an abandoned (reset) one never does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= IDLE;
      illegal <= 1'b0;
      retired <= 16'h0000;
    end else begin
      case (cur)
        IDLE:   cur <= FETCH;
        FETCH:  if (mem_ready) cur <= DECODE;
        DECODE: begin
          case (opcode)
            OP_RTYPE:     cur <= REXEC;
            OP_LW, OP_SW: cur <= MEMADR;
            OP_BEQ:       cur <= BEQ;
            OP_J:         cur <= JUMP;
            default: begin
              cur     <= TRAP;
              illegal <= 1'b1;
            end
          endcase
        end
        MEMADR: begin
          // opcode is held stable, so only lw/sw arrive here; anything else
          // means the instruction register was disturbed and is trapped.
          if (opcode == OP_LW)      cur <= MEMRD;
          else if (opcode == OP_SW) cur <= MEMWR;
          else begin
            cur     <= TRAP;
            illegal <= 1'b1;
          end
        end
        MEMRD:  if (mem_ready) cur <= MEMWB;
        MEMWR: begin
          if (mem_ready) begin
            cur     <= FETCH;
            retired <= retired + 16'd1;
          end
        end
        MEMWB, RWB, BEQ, JUMP: begin
          cur     <= FETCH;
          retired <= retired + 16'd1;
        end
        REXEC:  cur <= RWB;
        TRAP:   cur <= TRAP;
        default: cur <= IDLE;
      endcase
    end
  end

  assign state = cur;

  // Controls are decoded from the registered state; only the FETCH write
  // enables also look at mem_ready so a stalled fetch updates nothing.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDest     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    case (cur)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDest  = 1'b1;
      end
      BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver sets inputs each cycle and
// queues the expected outputs for that cycle; a negedge monitor pops and
// compares. Asynchronous reset behaviour is checked directly by the driver.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg;
  logic        IRWrite, ALUSrcA, RegWrite, RegDest;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state;
  logic        illegal;
  logic [15:0] retired;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDest(RegDest), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, BAD = 6'b111111;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        ill;
    logic [15:0] ret;
  } rec_t;

  rec_t        q[$];
  rec_t        mon_exp;
  rec_t        act;
  logic [15:0] ctrl_vec;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_ret = 16'h0000;
  logic        exp_ill = 1'b0;
  string       scen = "reset";

  assign ctrl_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg,
                     IRWrite, ALUSrcA, RegWrite, RegDest, ALUSrcB, ALUOp, PCSource};
  assign act = {state, ctrl_vec, illegal, retired};

  // Control table by state, same bit order as ctrl_vec.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] s, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd} = 10'b0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (s)
      4'd1:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd2:  asb = 2'b11;
      4'd3:  begin asa = 1'b1; asb = 2'b10; end
      4'd4:  begin mrd = 1'b1; iord = 1'b1; end
      4'd5:  begin rw = 1'b1; m2r = 1'b1; end
      4'd6:  begin mwr = 1'b1; iord = 1'b1; end
      4'd7:  begin asa = 1'b1; aop = 2'b10; end
      4'd8:  begin rw = 1'b1; rd = 1'b1; end
      4'd9:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      4'd10: begin pcw = 1'b1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, asb, aop, pcs};
  endfunction

  task automatic chk(input string name, input rec_t a, input rec_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t: got st=%0d ctrl=%h ill=%b ret=%h, want st=%0d ctrl=%h ill=%b ret=%h",
               name, $time, a.st, a.ctrl, a.ill, a.ret, e.st, e.ctrl, e.ill, e.ret);
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_exp = q.pop_front();
      chk(scen, act, mon_exp);
    end
  end

  // Drive one cycle: inputs for this cycle plus the expected outputs in it.
  task automatic step(input logic [3:0] s, input logic [5:0] op, input logic mr);
    opcode    = op;
    mem_ready = mr;
    if (s == 4'd11) exp_ill = 1'b1;
    q.push_back({s, exp_ctrl(s, mr), exp_ill, exp_ret});
    if (s == 4'd5 || s == 4'd8 || s == 4'd9 || s == 4'd10 || (s == 4'd6 && mr))
      exp_ret = exp_ret + 16'd1;
    @(posedge clk);
    #1;
  endtask

  // Assert reset off the clock edge and check outputs clear immediately.
  task automatic async_reset(input string name);
    #2;
    reset = 1'b1;
    #1;
    exp_ret = 16'h0000;
    exp_ill = 1'b0;
    chk(name, act, '0);
    @(posedge clk);
    #1;
    chk({name, "_hold"}, act, '0);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; opcode = BAD; mem_ready = 1'b1;
    #3;
    chk("reset_async_initial", act, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held_clocked", act, '0);
    reset = 1'b0;

    // lw, no stalls; garbage opcode in IDLE/FETCH and mem_ready=0 in DECODE
    // are ignored
    scen = "lw";
    step(0, BAD, 1'b0); step(1, BAD, 1'b1); step(2, LW, 1'b0);
    step(3, LW, 1'b0); step(4, LW, 1'b1); step(5, LW, 1'b0);

    // sw with two stall cycles in MEMWR
    scen = "sw_stall";
    step(1, BAD, 1'b1); step(2, SW, 1'b1); step(3, SW, 1'b1);
    step(6, SW, 1'b0); step(6, SW, 1'b0); step(6, SW, 1'b1);

    scen = "rtype";
    step(1, LW, 1'b1); step(2, RT, 1'b1); step(7, BAD, 1'b1); step(8, BAD, 1'b0);
    scen = "beq";
    step(1, RT, 1'b1); step(2, BQ, 1'b1); step(9, BAD, 1'b0);
    scen = "jump";
    step(1, BQ, 1'b1); step(2, JJ, 1'b1); step(10, BAD, 1'b0);

    // fetch stall for three cycles, then ready
    scen = "fetch_stall";
    step(1, BAD, 1'b0); step(1, BAD, 1'b0); step(1, BAD, 1'b0);
    step(1, BAD, 1'b1); step(2, JJ, 1'b1); step(10, JJ, 1'b1);

    // undefined opcode traps and stays, regardless of inputs
    scen = "trap";
    step(1, BAD, 1'b1); step(2, BAD, 1'b1); step(11, JJ, 1'b1);
    step(11, LW, 1'b0); step(11, RT, 1'b1);
    async_reset("trap_reset");

    // retire-counter wrap: 65535 jumps reach 0xFFFF, the next one wraps
    scen = "wrap_run";
    step(0, JJ, 1'b1);
    for (int i = 0; i < 65535; i++) begin
      step(1, JJ, 1'b1); step(2, JJ, 1'b1); step(10, JJ, 1'b1);
    end
    scen = "wrap_edge";
    step(1, JJ, 1'b1); step(2, JJ, 1'b1); step(10, JJ, 1'b1);

    // reset during a stalled MEMRD abandons the load
    scen = "memrd_abort";
    step(1, LW, 1'b1); step(2, LW, 1'b1); step(3, LW, 1'b1);
    step(4, LW, 1'b0); step(4, LW, 1'b0);
    async_reset("memrd_reset");
    scen = "restart";
    step(0, LW, 1'b1); step(1, LW, 1'b0); step(1, LW, 1'b1);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
